// File: rtl/exp_request_if.sv
// exp_request_if: exception request/acknowledge handshake between the request unit and the CPU
interface exp_request_if;
  logic has_exp;
  logic is_eret;
  logic expSrc0;
  logic expSrc1;
  logic expSrc2;
  modport master (input has_exp, is_eret, output expSrc0, expSrc1, expSrc2);
  modport slave (output has_exp, is_eret, input expSrc0, expSrc1, expSrc2);
endinterface

// File: rtl/exp_request_unit.sv
// exp_request_unit: debounces three request buttons and arbitrates them into one-at-a-time CPU exceptions
module exp_request_unit #(
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         btn,
  exp_request_if.master      cpu,
  output logic [2:0]         pending,
  output logic [1:0]         active_id,
  output logic               busy,
  output logic [2:0]         overrun,
  output logic [15:0]        served_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q;
  logic [2:0] sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0] ev, clr, pick;
  logic [2:0] pending_q, pending_d, overrun_q, overrun_d, exp_q;
  logic [1:0] active_id_q;
  logic busy_q;
  logic [15:0] served_q;
  // level flips only after DEBOUNCE consecutive disagreeing samples; any agreeing sample restarts the count
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == 8'(DEBOUNCE - 1)) deb_d[i] = ~deb_q[i];
        else cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end
  // rising debounced edges latch into pending; a set in the clearing cycle wins and is not an overrun
  always_comb begin
    ev = deb_q & ~deb_prev_q;
    clr = (state_q == REQ && cpu.has_exp) ? exp_q : 3'b000;
    pending_d = (pending_q & ~clr) | ev;
    overrun_d = overrun_q | (ev & pending_q & ~clr);
    pick = pending_q & (-pending_q);
  end
  // synchronizer, debounce and pending/overrun state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q <= '0;
      deb_prev_q <= '0;
      cnt_q <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end
  // request handshake FSM; arbitration happens only in IDLE so an active request is never preempted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      exp_q <= '0;
      active_id_q <= 2'd3;
      busy_q <= 1'b0;
      served_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|pending_q) begin
          state_q <= REQ;
          busy_q <= 1'b1;
          exp_q <= pick;
          active_id_q <= pick[0] ? 2'd0 : pick[1] ? 2'd1 : 2'd2;
        end
        REQ: if (cpu.has_exp) begin
          state_q <= SERVICE;
          exp_q <= '0;
          served_q <= served_q + 16'd1;
        end
        SERVICE: if (cpu.is_eret) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          active_id_q <= 2'd3;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cpu.expSrc0 = exp_q[0];
  assign cpu.expSrc1 = exp_q[1];
  assign cpu.expSrc2 = exp_q[2];
  assign pending = pending_q;
  assign overrun = overrun_q;
  assign active_id = active_id_q;
  assign busy = busy_q;
  assign served_cnt = served_q;
endmodule

// File: doc/exp_request_unit.md
EXP_REQUEST_UNIT -- requirements
Module: exp_request_unit

Interface
REQ-001 Parameter DEBOUNCE, default 4, SHALL set the number of consecutive stable synchronized samples needed to accept a button level change (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 btn  input  3  SHALL be the raw asynchronous request lines; bit i is the request for source i.
REQ-005 has_exp  input  1  SHALL be the CPU pulse meaning "exception accepted this cycle".
REQ-006 is_eret  input  1  SHALL be the CPU pulse meaning "ERET executed this cycle".
REQ-007 expSrc0, expSrc1, expSrc2  output  1 each  SHALL be the registered exception requests to the CPU, at most one high at any time.
REQ-008 pending  output  3  SHALL be the latched, not-yet-accepted requests.
REQ-009 active_id  output  2  SHALL be the source currently requested or in service; 2'd3 when none.
REQ-010 busy  output  1  SHALL be high in REQ and SERVICE.
REQ-011 overrun  output  3  SHALL be sticky per-source lost-event flags.
REQ-012 served_cnt  output  16  SHALL be the count of accepted exceptions.

Function
REQ-013 Each btn bit SHALL pass a 2-flop synchronizer, then a per-bit stability counter; the debounced level SHALL flip only after DEBOUNCE consecutive synchronized samples differ from it, and any matching sample SHALL reset the counter.
REQ-014 A 0->1 transition of a debounced level SHALL be an event; with btn held high from edge k, pending[i] SHALL be set at edge k+2+DEBOUNCE.
REQ-015 An event on source i while pending[i]=1 and not being cleared in that cycle SHALL set overrun[i] and leave pending[i] at 1.
REQ-016 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-017 IDLE: if pending!=0, SHALL go to REQ next edge and latch active_id = lowest-indexed set pending bit (source 0 highest priority).
REQ-018 REQ: expSrc[active_id] SHALL be 1 and all other expSrc outputs 0. The request SHALL be held until has_exp=1; on that edge the FSM SHALL move to SERVICE, clear pending[active_id], drop expSrc, and increment served_cnt.
REQ-019 served_cnt SHALL wrap from 16'hFFFF to 0.
REQ-020 SERVICE: expSrc SHALL be all 0. New events SHALL only latch into pending. On is_eret=1 the FSM SHALL go to IDLE and active_id SHALL become 3.
REQ-021 Re-arbitration SHALL happen only in IDLE, so the minimum gap between successive requests is one IDLE cycle.
REQ-022 A higher-priority event arriving while in REQ SHALL NOT preempt the active request.
REQ-023 An event on the active source in the same cycle its pending bit clears SHALL leave pending set (set wins) and SHALL NOT set overrun.
REQ-024 has_exp in IDLE or SERVICE, and is_eret in IDLE or REQ, SHALL be ignored.
REQ-025 has_exp and is_eret both high in REQ: has_exp SHALL be honoured and is_eret ignored.

Reset
REQ-026 While rst=0, regardless of clk, the block SHALL hold: FSM=IDLE, expSrc*=0, pending=0, overrun=0, active_id=3, busy=0, served_cnt=0, synchronizers, debounced levels and counters 0.
REQ-027 Reset asserted mid-REQ or mid-SERVICE SHALL abort the handshake with no pending state retained.
REQ-028 After rst deassertion, a btn line already high SHALL produce an event only after the full debounce latency in REQ-014.

Verification (DEBOUNCE=4)
REQ-029 Single request: btn=3'b010 held from edge 0 -> pending=3'b010 at edge 6, expSrc1=1 at edge 7; has_exp pulse -> expSrc1=0, served_cnt=1; is_eret -> busy=0, active_id=3.
REQ-030 Glitch rejection: btn[0] high for 3 cycles then low -> pending stays 0 and expSrc0 is never asserted.
REQ-031 Priority: btn=3'b101 rising together -> source 0 serviced first, then source 2 after is_eret plus one IDLE cycle; served_cnt=2.
REQ-032 Overrun: second debounced edge on btn[2] while pending[2]=1 in REQ -> overrun=3'b100 and pending[2] stays 1.
REQ-033 Set-wins: source 1 event coinciding with the has_exp edge for source 1 -> pending[1]=1 after the edge, overrun[1]=0.
REQ-034 Async reset: rst=0 mid-REQ between clock edges -> expSrc*=0, pending=0 and served_cnt=0 immediately, with no clock edge required.
